// File: rtl/vec_dot_product_chunk_accum_if.sv
// vec_dot_product_chunk_accum_if: partial-product beat input and frame-result output handshakes
interface vec_dot_product_chunk_accum_if #(
   parameter int IN_W = 19,
   parameter int MAX_CHUNKS = 256,
   localparam int ACC_W = IN_W + $clog2(MAX_CHUNKS),
   localparam int CNT_W = $clog2(MAX_CHUNKS + 1)
);
   logic in_valid;
   logic in_ready;
   logic [IN_W-1:0] in_data;
   logic in_last;
   logic out_valid;
   logic out_ready;
   logic [ACC_W-1:0] out_data;
   logic [CNT_W-1:0] out_count;
   logic out_err;
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count, out_err
   );
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count, out_err
   );
endinterface

// File: rtl/vec_dot_product_chunk_accum.sv
// vec_dot_product_chunk_accum: sums framed partial dot products into one held result per frame
// Optional DOT_ACCUM_CHUNK_LIMIT_EN force-closes a frame at MAX_CHUNKS beats and flags out_err.
module vec_dot_product_chunk_accum #(
   parameter int IN_W = 19,
   parameter int MAX_CHUNKS = 256,
   localparam int ACC_W = IN_W + $clog2(MAX_CHUNKS),
   localparam int CNT_W = $clog2(MAX_CHUNKS + 1)
) (
   input logic clk,
   input logic rst_n,
   vec_dot_product_chunk_accum_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
   state_t state, state_n;
   logic [ACC_W-1:0] acc, sum;
   logic [CNT_W-1:0] cnt, cnt_inc;
   logic accept, limit_hit, close;
   assign bus.out_valid = state == HOLD;
   assign bus.in_ready = !bus.out_valid;
   assign accept = bus.in_valid & bus.in_ready;
   assign sum = acc + ACC_W'(bus.in_data);
   assign cnt_inc = cnt + CNT_W'(1);
`ifdef DOT_ACCUM_CHUNK_LIMIT_EN
   logic err;
   assign limit_hit = cnt_inc == CNT_W'(MAX_CHUNKS);
   assign bus.out_err = err;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) err <= 1'b0;
      else if (accept && close) err <= limit_hit & !bus.in_last;
      else if (bus.out_valid && bus.out_ready) err <= 1'b0;
`else
   assign limit_hit = 1'b0;
   assign bus.out_err = 1'b0;
`endif
   assign close = bus.in_last | limit_hit;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      if (state == HOLD) state_n = bus.out_ready ? IDLE : HOLD;
      else if (accept) state_n = close ? HOLD : ACCUM;
   end
   // acc/cnt are zero whenever no frame is open, so IDLE needs no separate load path
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
         bus.out_data <= '0;
         bus.out_count <= '0;
      end else begin
         if (accept && close) begin
            bus.out_data <= sum;
            bus.out_count <= cnt_inc;
         end else if (accept) begin
            acc <= sum;
            cnt <= cnt_inc;
         end
         if (bus.out_valid && bus.out_ready) begin
            acc <= '0;
            cnt <= '0;
         end
      end
endmodule

// File: tb/tb_vec_dot_product_chunk_accum.sv
// tb_vec_dot_product_chunk_accum: directed and randomized frames checked against a frame-sum model
module tb_vec_dot_product_chunk_accum;
   localparam int IN_W = 19;
   localparam int MAX_CHUNKS = 256;
   localparam int ACC_W = IN_W + $clog2(MAX_CHUNKS);
   localparam int CNT_W = $clog2(MAX_CHUNKS + 1);
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   int beats[$];
   vec_dot_product_chunk_accum_if #(.IN_W(IN_W), .MAX_CHUNKS(MAX_CHUNKS)) bus ();
   vec_dot_product_chunk_accum #(.IN_W(IN_W), .MAX_CHUNKS(MAX_CHUNKS)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave)
   );
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_in_ready"}, bus.in_ready, 1);
      chk({tag, "_out_data"}, bus.out_data, 0);
      chk({tag, "_out_count"}, bus.out_count, 0);
      chk({tag, "_out_err"}, bus.out_err, 0);
   endtask

   task automatic fill(input int n, input int v);
      beats.delete();
      repeat (n) beats.push_back(v < 0 ? int'($urandom_range(520200)) : v);
   endtask

   task automatic result(input longint exp_d, input int exp_c, input bit exp_e, input int hold);
      int k = hold < 0 ? int'($urandom_range(4)) : hold;
      bus.out_ready = 0;
      chk("out_valid", bus.out_valid, 1);
      chk("out_data", bus.out_data, 64'(exp_d));
      chk("out_count", bus.out_count, 64'(exp_c));
      chk("out_err", bus.out_err, 64'(exp_e));
      chk("in_ready_hold", bus.in_ready, 0);
      repeat (k) begin
         bus.in_valid = 1;
         bus.in_data = IN_W'($urandom);
         bus.in_last = 1'($urandom);
         step();
         chk("held_valid", bus.out_valid, 1);
         chk("held_data", bus.out_data, 64'(exp_d));
         chk("held_count", bus.out_count, 64'(exp_c));
         chk("held_in_ready", bus.in_ready, 0);
      end
      bus.in_valid = 0;
      bus.out_ready = 1;
      step();
      bus.out_ready = 0;
      chk("released_valid", bus.out_valid, 0);
      chk("released_in_ready", bus.in_ready, 1);
      chk("released_err", bus.out_err, 0);
   endtask

   // Model: a frame closes on in_last (or at MAX_CHUNKS beats when the limit is enabled); result is the plain sum.
   task automatic run_frame(input int hold, input int gap);
      longint sum = 0;
      int cnt = 0;
      int n = beats.size();
      bit last, forced;
      for (int i = 0; i < n; i++) begin
`ifndef DOT_ACCUM_CHUNK_LIMIT_EN
         checks++;
         assert (cnt < MAX_CHUNKS) else begin
            errors++;
            $error("FAIL illegal_frame beats_open=%0d limit=%0d", cnt, MAX_CHUNKS);
         end
`endif
         if (i > 0) begin
            int g = gap < 0 ? ($urandom_range(3) == 0 ? int'($urandom_range(2, 1)) : 0) : gap;
            repeat (g) begin
               bus.in_valid = 0;
               bus.in_data = IN_W'($urandom);
               bus.in_last = 1'($urandom);
               bus.out_ready = 1'($urandom);
               step();
            end
         end
         chk("in_ready_beat", bus.in_ready, 1);
         last = i == n - 1;
         bus.in_valid = 1;
         bus.in_data = IN_W'(beats[i]);
         bus.in_last = last;
         bus.out_ready = 1'($urandom);
         step();
         sum += beats[i];
         cnt++;
         forced = 0;
`ifdef DOT_ACCUM_CHUNK_LIMIT_EN
         forced = !last && cnt == MAX_CHUNKS;
`endif
         if (last || forced) begin
            result(sum % (64'd1 << ACC_W), cnt, forced, hold);
            sum = 0;
            cnt = 0;
         end
      end
      bus.in_valid = 0;
   endtask

   initial begin
      bus.in_valid = 0;
      bus.in_data = '0;
      bus.in_last = 0;
      bus.out_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("in_reset");
      #3 rst_n = 1;
      step();
      chk_reset_outputs("after_release");
      fill(1, 520200);
      run_frame(2, 0);
      beats = '{520200, 1000};
      run_frame(0, 1);
      fill(4, -1);
      run_frame(5, -1);
      fill(3, -1);
      run_frame(0, -1);
      fill(MAX_CHUNKS, 520200);
      run_frame(1, -1);
`ifdef DOT_ACCUM_CHUNK_LIMIT_EN
      fill(MAX_CHUNKS + 2, 1);
      run_frame(0, 0);
`endif
      repeat (10) begin
         fill($urandom_range(20, 1), -1);
         run_frame(-1, -1);
      end
      repeat (3) begin
         bus.in_valid = 1;
         bus.in_data = 7;
         bus.in_last = 0;
         step();
      end
      bus.in_valid = 0;
      #3 rst_n = 0;
      #1;
      chk_reset_outputs("mid_frame_reset");
      #3 rst_n = 1;
      step();
      chk("post_reset_in_ready", bus.in_ready, 1);
      fill(1, 5);
      run_frame(0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vec_dot_product_chunk_accum.md
Name: vec_dot_product_chunk_accum

Overview:
Streaming accumulator placed directly downstream of the 8-lane (64-bit) combinational dot-product unit. It consumes one 19-bit partial dot product per accepted beat and sums a framed sequence of beats, delimited by in_last, into the dot product of a long vector. It presents one result per frame on a valid/ready output port. Both ports use a registered handshake.

Parameters:
IN_W, 19, width of each incoming partial dot product (8 lanes x 8b x 8b).
MAX_CHUNKS, 256, maximum number of beats per frame; sets accumulator and count widths.
ACC_W, IN_W+$clog2(MAX_CHUNKS), accumulator/result width (27 at defaults); derived, not overridden.
CNT_W, $clog2(MAX_CHUNKS+1), beat-count width (9 at defaults); derived.

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk
in_valid  in  1  partial product present
in_ready  out  1  block can accept a beat
in_data  in  IN_W  partial dot product (unsigned)
in_last  in  1  final beat of the current frame
out_valid  out  1  frame result held
out_ready  in  1  consumer takes result
out_data  out  ACC_W  frame sum (unsigned)
out_count  out  CNT_W  beats summed into out_data
out_err  out  1  frame was force-terminated (only meaningful with the optional feature; otherwise tied 0)

Behaviour:
- Reset: state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_count=0, out_err=0. in_ready=1 on the first cycle after release. Reset asserted mid-frame or while a result is held discards everything; no partial result is ever emitted.
- Accept: accept = in_valid & in_ready. in_ready = !out_valid (combinational from the register). No beat is accepted while a result is held.
- States:
  - IDLE: no frame open. An accepted beat with in_last=0 loads acc=in_data, cnt=1 -> ACCUM. An accepted beat with in_last=1 is a single-beat frame and goes straight to HOLD.
  - ACCUM: each accepted beat adds: acc+=in_data, cnt+=1. A beat with in_last=1 -> HOLD. Cycles with no accepted beat leave state unchanged.
  - HOLD: out_valid=1; out_data and out_count are stable until out_ready=1. On out_valid & out_ready: out_valid<=0, acc<=0, cnt<=0 -> IDLE.
- Latency: the result is visible the cycle after the in_last beat is accepted. out_data = acc + in_data of the last beat. The final add is registered directly into out_data; there is no extra stage.
- Throughput: one bubble per frame. in_ready drops for at least one cycle, HOLD lasts at least one cycle, and in_ready returns the cycle after the output handshake.
- Arithmetic: unsigned, zero-extended from IN_W to ACC_W. No overflow is possible for frames of up to MAX_CHUNKS beats.
- in_valid=0 gaps inside a frame are allowed and are not counted.
- in_data and in_last are ignored when no beat is accepted.
- out_ready while out_valid=0 is ignored.

Optional Feature:
Macro: DOT_ACCUM_CHUNK_LIMIT_EN.
- Defined: when the MAX_CHUNKS-th beat of a frame is accepted with in_last=0, the block treats that beat as last. It goes to HOLD with out_count=MAX_CHUNKS and out_err=1. out_err clears on the output handshake. The beats that follow are taken as the start of a new frame.
- Undefined: out_err is tied 0. A beat accepted when cnt=MAX_CHUNKS wraps acc modulo 2^ACC_W and cnt modulo 2^CNT_W, with no indication. Such frames are illegal usage, and the testbench must flag them as an assertion failure.

Test Plan:
- Single-beat frame: in_data=520200 (all bytes 0xFF), in_last=1 -> next cycle out_valid=1, out_data=520200, out_count=1; in_ready=0 until out_ready is taken.
- Two-beat frame, with a one-cycle in_valid gap between beats: 520200 then 1000 (last) -> out_data=521200, out_count=2; the gap cycle does not change cnt.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and new data -> out_data stable, in_ready=0 throughout, no beat lost. Release out_ready -> in_ready=1 on the next cycle and the next frame sums correctly.
- Max frame: 256 beats of 520200, last on beat 256 -> out_data=133171200 (fits in 27b), out_count=256, out_err=0.
- Limit (macro defined): 258 beats of 1, last on beat 258 -> first result out_data=256, out_count=256, out_err=1; second result out_data=2, out_count=2, out_err=0.
- Reset mid-frame: after 3 beats of 7, pulse rst_n low asynchronously (between clock edges) -> outputs immediately at reset values. A following frame of one beat of 5 (last) -> out_data=5, out_count=1.
